serial_wb_regslave: RTL and testbench
=====================================

# serial_wb_regslave

Wishbone slave holding a bank of 32-bit read/write configuration registers. It is the responder for the serial Wishbone master: the master issues single classic cycles, and this block terminates each one with `ack`, `err` or `rty` after a fixed number of wait states. The register contents are exported in parallel to drive logic-analyzer configuration such as trigger masks and sample counts.

## Interface
Parameters:
- `ADDR_BITS`, default 3: word-index width; the bank holds 2^ADDR_BITS registers.
- `WAIT_STATES`, default 1, range 0–15: idle cycles inserted before termination.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `wbs_adr_i` in 32: byte address. Bits [1:0] are ignored; bits [ADDR_BITS+1:2] give the word index.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data.
- `wbs_sel_i` in 4: byte lane enables. Bit n enables bits [8n+7:8n].
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone cycle, strobe and write-enable.
- `wbs_lock_i` in 1: ignored.
- `wbs_ack_o`, `wbs_err_o`, `wbs_rty_o` out 1 each: termination signals.
- `busy_i` in 1: when high, new accesses are refused with retry.
- `regs_o` out 32·2^ADDR_BITS: flattened register bank. Register k occupies bits [32k+31:32k].

## Operation
- Request: `req` = `wbs_cyc_i & wbs_stb_i`.
- Out of range: a request is out of range when `wbs_adr_i[31:ADDR_BITS+2]` is not zero.
- State machine has three states:
  - IDLE: on `req`, capture the kind of response. Out of range gives ERR, else `busy_i` gives RTY, else OK. Error takes priority over retry.
    - WAIT_STATES = 0: go to TERM.
    - Otherwise: load the counter with WAIT_STATES−1 and go to WAIT.
  - WAIT: if `req` drops, go to IDLE (abort). No termination is issued and no write occurs. Otherwise, at counter 0 go to TERM; else decrement the counter.
  - TERM: the single termination cycle. Always return to IDLE on the next edge.
- Only the response kind is captured in IDLE. Address, data, sel and we are taken from the bus at the edge that enters TERM; Wishbone requires them to be stable while `stb` is high. `busy_i` is sampled only in IDLE.
- Outputs in TERM:
  - OK: `wbs_ack_o`=1.
  - ERR: `wbs_err_o`=1.
  - RTY: `wbs_rty_o`=1.
  - Exactly one termination signal is high in TERM. All three are low in IDLE and WAIT.
- Write (OK and `wbs_we_i`=1): at the edge entering TERM, update only the byte lanes of the indexed register whose `wbs_sel_i` bit is set. A write with `sel`=0 still acks and changes nothing.
- Read (OK and `wbs_we_i`=0): at the same edge, `wbs_dat_o` loads the indexed register, masked per byte by `wbs_sel_i`; unselected lanes read 0.
- `wbs_dat_o` is 0 in every cycle other than an OK-read TERM cycle, including ERR/RTY terminations and write acks.
- ERR and RTY terminations never modify registers.
- `regs_o` is driven directly from the register flops.

## Timing
- Reset (`rst_i`=1 at a clock edge) forces:
  - state IDLE, counter 0;
  - every register 0, so `regs_o` is all zeros;
  - `wbs_ack_o`, `wbs_err_o`, `wbs_rty_o` and `wbs_dat_o` all 0.
- Reset mid-transaction drops any pending termination and write.
- All outputs are registered; there is no combinational path from input to output.
- Latency: if `req` is first high in cycle N, the termination signal is high in cycle N+WAIT_STATES+1, for exactly one cycle.
- Back-to-back: if `stb` stays high after the termination cycle, IDLE treats it as a new request. With W = WAIT_STATES, terminations are therefore at least W+2 cycles apart.
- Written data is visible on `regs_o` in the termination cycle itself, and to a read that starts in the next cycle.
- Wishbone requires the master to drop `stb` in the cycle after termination. The slave does not depend on it.

## Test plan
- Write then read, defaults (ADDR_BITS=3, WAIT_STATES=1):
  - write 0xDEADBEEF to 0x0C with sel=0xF → ack exactly 2 cycles after `stb` rises; `regs_o[127:96]`=0xDEADBEEF;
  - read 0x0C → ack with `wbs_dat_o`=0xDEADBEEF.
- Byte lanes: register 0 holds 0x11223344.
  - Write 0xAABBCCDD with sel=0b0101 → register becomes 0x11BB33DD.
  - Read with sel=0b0010 → `wbs_dat_o`=0x00003300.
- Error: access to address 0x20 → `wbs_err_o` pulses once, with `ack` and `rty` low and `dat_o`=0; `regs_o` unchanged. Also with `busy_i`=1 → still `err`, not `rty`.
- Retry: `busy_i`=1 on a write to 0x04 → `rty` pulse and register 1 unchanged. Release `busy_i` and reissue → `ack` and register updated.
- Abort and reset, WAIT_STATES=3:
  - drop `stb` after 2 cycles → no termination pulse ever, register unchanged;
  - assert `rst_i` during WAIT → all outputs 0 on the next cycle, `regs_o` all zeros.
- Wait-state sweep: WAIT_STATES=0 and 15 → termination in cycle N+1 and N+16 respectively. Holding `stb` high continuously gives termination pulses spaced WAIT_STATES+2 cycles apart.

Source files
------------

// File: rtl/serial_wb_regslave.sv
// serial_wb_regslave: Wishbone register-bank slave with fixed wait states and ack/err/rty termination
module serial_wb_regslave #(
  parameter int ADDR_BITS   = 3,
  parameter int WAIT_STATES = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic [31:0]                 wbs_dat_o,
  input  logic [3:0]                  wbs_sel_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic                        wbs_lock_i,
  output logic                        wbs_ack_o,
  output logic                        wbs_err_o,
  output logic                        wbs_rty_o,
  input  logic                        busy_i,
  output logic [32*(1<<ADDR_BITS)-1:0] regs_o
);
  localparam int N = 1 << ADDR_BITS;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;
  typedef enum logic [1:0] {K_OK, K_ERR, K_RTY} kind_t;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] regs_q [N];
  logic [31:0] regs_d [N];
  logic req, oor, enter_ok;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] mask;
  logic unused_ok;
  assign unused_ok = ^{wbs_lock_i, wbs_adr_i[1:0]};
  assign req  = wbs_cyc_i & wbs_stb_i;
  assign oor  = |wbs_adr_i[31:ADDR_BITS+2];
  assign idx  = wbs_adr_i[ADDR_BITS+1:2];
  assign mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign enter_ok = (state_d == S_TERM) && (state_q != S_TERM) && (kind_d == K_OK);
  // Next state, response kind capture, and the access performed on the edge entering TERM
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    dat_d   = '0;
    case (state_q)
      S_IDLE: if (req) begin
        kind_d  = oor ? K_ERR : busy_i ? K_RTY : K_OK;
        state_d = (WAIT_STATES == 0) ? S_TERM : S_WAIT;
        cnt_d   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      end
      S_WAIT: begin
        state_d = !req ? S_IDLE : (cnt_q == 4'd0) ? S_TERM : S_WAIT;
        cnt_d   = (req && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_ok && wbs_we_i) regs_d[idx] = (regs_q[idx] & ~mask) | (wbs_dat_i & mask);
    if (enter_ok && !wbs_we_i) dat_d = regs_q[idx] & mask;
  end
  // State, counter, read data and register bank
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      kind_q  <= K_OK;
      cnt_q   <= '0;
      dat_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      regs_q  <= regs_d;
    end
  end
  assign wbs_ack_o = (state_q == S_TERM) && (kind_q == K_OK);
  assign wbs_err_o = (state_q == S_TERM) && (kind_q == K_ERR);
  assign wbs_rty_o = (state_q == S_TERM) && (kind_q == K_RTY);
  assign wbs_dat_o = dat_q;
  for (genvar k = 0; k < N; k++) begin : g_regs
    assign regs_o[32*k +: 32] = regs_q[k];
  end
endmodule

// File: tb/tb_serial_wb_regslave.sv
// tb_serial_wb_regslave: scoreboard bench over four slaves with 0, 1, 3 and 15 wait states
module tb_serial_wb_regslave;
  typedef struct {
    int         idx;
    logic [2:0] t;
    logic [31:0] dat;
    int         cyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cycle = 0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t e;
  logic [2:0] t;
  logic [31:0] adr [4];
  logic [31:0] dat_i [4];
  logic [31:0] dat_o [4];
  logic [3:0] sel [4];
  logic cyc_i [4];
  logic stb [4];
  logic we [4];
  logic busy [4];
  logic ack [4];
  logic err [4];
  logic rty [4];
  logic [255:0] regs [4];
  logic [255:0] m;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_wb_regslave #(
      .ADDR_BITS(3),
      .WAIT_STATES(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 3 : 15)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .wbs_adr_i(adr[g]), .wbs_dat_i(dat_i[g]), .wbs_dat_o(dat_o[g]),
      .wbs_sel_i(sel[g]), .wbs_cyc_i(cyc_i[g]), .wbs_stb_i(stb[g]),
      .wbs_we_i(we[g]), .wbs_lock_i(1'b0),
      .wbs_ack_o(ack[g]), .wbs_err_o(err[g]), .wbs_rty_o(rty[g]),
      .busy_i(busy[g]), .regs_o(regs[g])
    );
  end
  function automatic int ws(input int i);
    return i == 0 ? 0 : i == 1 ? 1 : i == 2 ? 3 : 15;
  endfunction
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  task automatic start(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic b);
    adr[i] = a; dat_i[i] = d; sel[i] = s; we[i] = w; busy[i] = b; cyc_i[i] = 1; stb[i] = 1;
  endtask
  task automatic drop(input int i);
    adr[i] = 0; dat_i[i] = 0; sel[i] = 0; we[i] = 0; busy[i] = 0; cyc_i[i] = 0; stb[i] = 0;
  endtask
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic b, input logic [2:0] tt, input logic [31:0] ed, input int n);
    exp_t x;
    start(i, w, a, d, s, b);
    for (int k = 0; k < n; k++) begin
      x.idx = i; x.t = tt; x.dat = ed; x.cyc = cycle + ws(i) + 1 + k * (ws(i) + 2);
      q.push_back(x);
    end
    repeat (n * (ws(i) + 2)) @(posedge clk);
    #1 drop(i);
  endtask
  // Scoreboard monitor: every termination must match the queue head in kind, data and cycle
  always @(negedge clk) if (!rst) begin
    if (q.size() > 0 && q[0].cyc < cycle) begin
      tests++; fails++;
      $display("FAIL missing_term dut%0d: no termination by cycle %0d, required at %0d", q[0].idx, cycle, q[0].cyc);
      void'(q.pop_front());
    end
    for (int g = 0; g < 4; g++) begin
      t = {ack[g], err[g], rty[g]};
      if (t != 3'b000) begin
        tests++;
        if (q.size() == 0 || q[0].idx != g) begin
          fails++;
          $display("FAIL unexpected_term dut%0d: got ack/err/rty=%b at cycle %0d, required none", g, t, cycle);
        end else begin
          e = q.pop_front();
          if (t !== e.t || dat_o[g] !== e.dat || cycle != e.cyc) begin
            fails++;
            $display("FAIL term dut%0d: got t=%b dat=%h cyc=%0d, required t=%b dat=%h cyc=%0d", g, t, dat_o[g], cycle, e.t, e.dat, e.cyc);
          end
        end
      end else if (dat_o[g] !== 32'h0) begin
        tests++; fails++;
        $display("FAIL idle_dat dut%0d: got %h required 0 at cycle %0d", g, dat_o[g], cycle);
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) drop(i);
    m = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_outputs", {ack[i], err[i], rty[i], dat_o[i]}, '0);
      chk("rst_regs", regs[i], '0);
    end
    rst = 0;
    @(posedge clk); #1;
    txn(1, 1, 32'h0C, 32'hDEADBEEF, 4'hF, 0, 3'b100, 32'h0, 1);
    m[127:96] = 32'hDEADBEEF;
    chk("write_c", regs[1], m);
    txn(1, 0, 32'h0C, 32'h0, 4'hF, 0, 3'b100, 32'hDEADBEEF, 1);
    txn(1, 0, 32'h0F, 32'h0, 4'hF, 0, 3'b100, 32'hDEADBEEF, 1);
    txn(1, 1, 32'h00, 32'h11223344, 4'hF, 0, 3'b100, 32'h0, 1);
    m[31:0] = 32'h11223344;
    chk("write_0", regs[1], m);
    txn(1, 1, 32'h00, 32'hAABBCCDD, 4'b0101, 0, 3'b100, 32'h0, 1);
    m[31:0] = 32'h11BB33DD;
    chk("byte_lanes", regs[1], m);
    txn(1, 0, 32'h00, 32'h0, 4'b0010, 0, 3'b100, 32'h00003300, 1);
    txn(1, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 3'b010, 32'h0, 1);
    chk("err_regs", regs[1], m);
    txn(1, 0, 32'h20, 32'h0, 4'hF, 1, 3'b010, 32'h0, 1);
    txn(1, 1, 32'h80000004, 32'hFFFFFFFF, 4'hF, 0, 3'b010, 32'h0, 1);
    chk("err_hi_regs", regs[1], m);
    txn(1, 1, 32'h04, 32'h12345678, 4'hF, 1, 3'b001, 32'h0, 1);
    chk("rty_regs", regs[1], m);
    txn(1, 1, 32'h04, 32'h12345678, 4'hF, 0, 3'b100, 32'h0, 1);
    m[63:32] = 32'h12345678;
    chk("retry_ok", regs[1], m);
    txn(1, 1, 32'h04, 32'hFFFFFFFF, 4'h0, 0, 3'b100, 32'h0, 1);
    chk("sel_zero", regs[1], m);
    txn(1, 0, 32'h04, 32'h0, 4'hF, 1, 3'b001, 32'h0, 1);
    txn(1, 0, 32'h04, 32'h0, 4'hF, 0, 3'b100, 32'h12345678, 3);
    txn(0, 1, 32'h1C, 32'hA5A50F0F, 4'hF, 0, 3'b100, 32'h0, 1);
    chk("ws0_write", regs[0], {32'hA5A50F0F, 224'h0});
    txn(0, 0, 32'h1C, 32'h0, 4'hF, 0, 3'b100, 32'hA5A50F0F, 3);
    txn(3, 1, 32'h08, 32'h0BADF00D, 4'hF, 0, 3'b100, 32'h0, 1);
    chk("ws15_write", regs[3], {160'h0, 32'h0BADF00D, 64'h0});
    txn(3, 0, 32'h08, 32'h0, 4'hF, 0, 3'b100, 32'h0BADF00D, 2);
    start(2, 1, 32'h08, 32'hCAFEF00D, 4'hF, 0);
    repeat (2) @(posedge clk);
    #1 drop(2);
    repeat (8) @(posedge clk);
    #1 chk("abort_regs", regs[2], '0);
    txn(2, 1, 32'h08, 32'h5A5A5A5A, 4'hF, 0, 3'b100, 32'h0, 1);
    chk("ws3_write", regs[2], {160'h0, 32'h5A5A5A5A, 64'h0});
    start(2, 1, 32'h0C, 32'h77777777, 4'hF, 0);
    @(posedge clk); #1;
    rst = 1;
    drop(2);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_outputs", {ack[i], err[i], rty[i], dat_o[i]}, '0);
      chk("midrst_regs", regs[i], '0);
    end
    repeat (8) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
